msg_fifo_arbiter: RTL

//  Shares the single 32-bit CPU message FIFO between N_SRC message producers (red/blue box

---
 rtl/msg_fifo_arbiter_if.sv | 40 ++++
 rtl/msg_fifo_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/msg_fifo_arbiter_if.sv
// Bus bundle between the message producers, the arbiter and the downstream CPU message FIFO.
//
// Ports (signals):
//   req        producers -> arbiter  req[i]: producer i holds a valid message
//   msg_id     producers -> arbiter  word 0 of source i, bits [32i+31:32i]
//   msg_tl     producers -> arbiter  word 1 (top-left) of source i
//   msg_br     producers -> arbiter  word 2 (bottom-right) of source i
//   ack        arbiter -> producers  one-cycle capture pulse per source
//   fifo_data  arbiter -> FIFO       write data, zero when not writing
//   fifo_wr    arbiter -> FIFO       write request
//   fifo_usedw FIFO -> arbiter       used words
//   fifo_full  FIFO -> arbiter       full flag
//   flush      FIFO -> arbiter       FIFO being cleared this cycle
//
// Modports: master = arbiter side, slave = producers/FIFO environment side.
interface msg_fifo_arbiter_if #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned USEDW_W = 8
);
    logic [N_SRC-1:0]    req;
    logic [32*N_SRC-1:0] msg_id;
    logic [32*N_SRC-1:0] msg_tl;
    logic [32*N_SRC-1:0] msg_br;
    logic [N_SRC-1:0]    ack;
    logic [31:0]         fifo_data;
    logic                fifo_wr;
    logic [USEDW_W-1:0]  fifo_usedw;
    logic                fifo_full;
    logic                flush;

    modport master (
        input  req, msg_id, msg_tl, msg_br, fifo_usedw, fifo_full, flush,
        output ack, fifo_data, fifo_wr
    );

    modport slave (
        output req, msg_id, msg_tl, msg_br, fifo_usedw, fifo_full, flush,
        input  ack, fifo_data, fifo_wr
    );
endinterface

// File: rtl/msg_fifo_arbiter.sv
// Shares one 32-bit CPU message FIFO between N_SRC producers. Each producer offers an atomic
// 3-word message (ID, top-left, bottom-right). A round-robin grant is issued only when the
// FIFO has room for a whole message; the captured words are then streamed on three
// consecutive cycles so messages are never interleaved or truncated.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   bus        msg_fifo_arbiter_if.master: producer req/data/ack and FIFO write side
//   busy       a message is being written (state != idle)
//   grant_idx  index of the last granted source
//   msg_count  completed messages, wraps modulo 2^16
module msg_fifo_arbiter #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned MSG_WORDS  = 3
) (
    input  logic               clk,
    input  logic               reset,
    msg_fifo_arbiter_if.master bus,
    output logic               busy,
    output logic [2:0]         grant_idx,
    output logic [15:0]        msg_count
);

    localparam int unsigned RoomLimit = FIFO_DEPTH - MSG_WORDS;

    typedef enum logic [1:0] {
        StIdle,
        StWId,
        StWTl,
        StWBr
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  grant_idx_q, grant_idx_d;
    logic [15:0] msg_count_q, msg_count_d;
    logic [31:0] id_q, id_d;
    logic [31:0] tl_q, tl_d;
    logic [31:0] br_q, br_d;

    // Unpack the flat source buses into fixed 8-entry tables so the winner can be picked
    // with a plain 3-bit index; unused slots read as zero.
    logic [7:0]  req_pad;
    logic [31:0] id_arr [8];
    logic [31:0] tl_arr [8];
    logic [31:0] br_arr [8];

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < N_SRC) begin : g_src
            assign req_pad[g] = bus.req[g];
            assign id_arr[g]  = bus.msg_id[32*g +: 32];
            assign tl_arr[g]  = bus.msg_tl[32*g +: 32];
            assign br_arr[g]  = bus.msg_br[32*g +: 32];
        end else begin : g_pad
            assign req_pad[g] = 1'b0;
            assign id_arr[g]  = '0;
            assign tl_arr[g]  = '0;
            assign br_arr[g]  = '0;
        end
    end

    // Whole-message room check; room is only consulted at grant time since nothing else
    // writes the FIFO.
    logic room;
    assign room = ~bus.fifo_full && (32'(bus.fifo_usedw) < RoomLimit);

    // Round-robin search starting one past the last grant, wrapping modulo N_SRC.
    logic       win_found;
    logic [2:0] win_idx;
    logic [3:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = grant_idx_q;
        cand      = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= int'(N_SRC)) begin
                cand = {1'b0, grant_idx_q} + 4'(k);
                if (cand >= 4'(N_SRC)) begin
                    cand = cand - 4'(N_SRC);
                end
                if (!win_found && req_pad[cand[2:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[2:0];
                end
            end
        end
    end

    logic [7:0] ack_pad;

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        msg_count_d   = msg_count_q;
        id_d          = id_q;
        tl_d          = tl_q;
        br_d          = br_q;
        ack_pad       = '0;
        bus.fifo_wr   = 1'b0;
        bus.fifo_data = '0;

        unique case (state_q)
            StIdle: begin
                // Gate with reset so no ack escapes while the block is being reset.
                if (win_found && room && !bus.flush && !reset) begin
                    id_d        = id_arr[win_idx];
                    tl_d        = tl_arr[win_idx];
                    br_d        = br_arr[win_idx];
                    ack_pad     = 8'd1 << win_idx;
                    grant_idx_d = win_idx;
                    state_d     = StWId;
                end
            end
            StWId: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    bus.fifo_wr   = 1'b1;
                    bus.fifo_data = id_q;
                    state_d       = StWTl;
                end
            end
            StWTl: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    bus.fifo_wr   = 1'b1;
                    bus.fifo_data = tl_q;
                    state_d       = StWBr;
                end
            end
            StWBr: begin
                state_d = StIdle;
                // A flushed message is discarded and does not count as completed.
                if (!bus.flush) begin
                    bus.fifo_wr   = 1'b1;
                    bus.fifo_data = br_q;
                    msg_count_d   = msg_count_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ack   = ack_pad[N_SRC-1:0];
    assign busy      = (state_q != StIdle);
    assign grant_idx = grant_idx_q;
    assign msg_count = msg_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_idx_q <= 3'(N_SRC - 1);
            msg_count_q <= '0;
            id_q        <= '0;
            tl_q        <= '0;
            br_q        <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            msg_count_q <= msg_count_d;
            id_q        <= id_d;
            tl_q        <= tl_d;
            br_q        <= br_d;
        end
    end

endmodule
